// File: rtl/exception_sequencer_pkg.sv
// COP0 exception record type plus the sequencer's shared state enum,
// ExcCode constants and default vector parameters.

package cop0_info;

    // Status register bit positions used by the exception logic
    localparam int STATUS_IE     = 0;
    localparam int STATUS_EXL    = 1;
    localparam int STATUS_ERL    = 2;
    localparam int STATUS_IM_LSB = 8;
    localparam int STATUS_BEV    = 22;

    // Registered exception record handed to COP0
    typedef struct packed {
        logic        exception_happen;
        logic [4:0]  exc_code;
        logic [31:0] epc;
        logic        in_bd;
        logic [31:0] badvaddr;
        logic        load_addr;
    } cop0_exc_data_t;

endpackage

package exception_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_FLUSH    = 2'd1,
        ST_REDIRECT = 2'd2
    } seq_state_t;

    localparam logic [4:0] EXCCODE_INT  = 5'h00;
    localparam logic [4:0] EXCCODE_ADEL = 5'h04;
    localparam logic [4:0] EXCCODE_ADES = 5'h05;
    localparam logic [4:0] EXCCODE_SYS  = 5'h08;
    localparam logic [4:0] EXCCODE_BP   = 5'h09;
    localparam logic [4:0] EXCCODE_RI   = 5'h0A;
    localparam logic [4:0] EXCCODE_CU   = 5'h0B;
    localparam logic [4:0] EXCCODE_OV   = 5'h0C;
    localparam logic [4:0] EXCCODE_TR   = 5'h0D;

    localparam logic [31:0] BEV_BASE_DEFAULT    = 32'hBFC0_0200;
    localparam logic [31:0] OFF_GENERAL_DEFAULT = 32'h0000_0180;
    localparam logic [31:0] OFF_IRQ_DEFAULT     = 32'h0000_0200;

    // Vector address: plain 32-bit wrap-around add, carry discarded
    function automatic logic [31:0] vector_pc(input logic [31:0] base,
                                              input logic [31:0] offset);
        return base + offset;
    endfunction

endpackage

// File: rtl/exception_sequencer_irq_synchronizer.sv
// Double-flop synchroniser for the raw interrupt lines, masked by Status.IM.

module irq_synchronizer #(
    parameter int N_IRQ = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_IRQ-1:0] irq,
    input  logic [N_IRQ-1:0] im,
    output logic [N_IRQ-1:0] irq_pending
);

    logic [N_IRQ-1:0] sync1;
    logic [N_IRQ-1:0] sync2;

    // Two-stage synchroniser chain, cleared by reset
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= irq;
            sync2 <= sync1;
        end
    end

    assign irq_pending = sync2 & im;

endmodule

// File: rtl/exception_sequencer.sv
// Prioritises synchronous exceptions, interrupts and ERET, captures the
// winner into the COP0 record, flushes the pipeline for FLUSH_CYCLES and
// then offers the redirect PC to fetch.
//
// Redirect handshake: redirect_valid rises in REDIRECT and stays high with
// redirect_pc stable until a cycle where redirect_ready is also high; that
// edge completes the transfer and the sequencer returns to IDLE. There is no
// way to withdraw a redirect other than reset.

module exception_sequencer
    import cop0_info::*;
    import exception_sequencer_pkg::*;
#(
    parameter int          N_SRC        = 4,
    parameter int          N_IRQ        = 8,
    parameter int          FLUSH_CYCLES = 2,
    parameter logic [31:0] BEV_BASE     = BEV_BASE_DEFAULT,
    parameter logic [31:0] OFF_GENERAL  = OFF_GENERAL_DEFAULT,
    parameter logic [31:0] OFF_IRQ      = OFF_IRQ_DEFAULT
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [N_SRC-1:0]            src_valid,
    input  logic [N_SRC-1:0][4:0]       src_code,
    input  logic [N_SRC-1:0][31:0]      src_epc,
    input  logic [N_SRC-1:0]            src_in_bd,
    input  logic [N_SRC-1:0][31:0]      src_badvaddr,
    input  logic [N_SRC-1:0]            src_load_addr,
    input  logic [N_IRQ-1:0]            irq,
    input  logic [31:0]                 irq_epc,
    input  logic                        irq_in_bd,
    input  logic [31:0]                 status,
    input  logic                        cause_iv,
    input  logic [31:0]                 ebase,
    input  logic                        eret,
    input  logic [31:0]                 eret_target,
    input  logic                        redirect_ready,
    output cop0_info::cop0_exc_data_t   exc_data,
    output logic                        flush,
    output logic                        redirect_valid,
    output logic [31:0]                 redirect_pc,
    output logic                        busy,
    output logic [N_IRQ-1:0]            irq_pending,
    output seq_state_t                  state_dbg
);

    localparam int              CNT_W    = $clog2(FLUSH_CYCLES + 1);
    localparam int              SRC_W    = (N_SRC > 1) ? $clog2(N_SRC) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FLUSH_CYCLES - 1);

    seq_state_t       state;
    seq_state_t       state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             accept;

    logic             src_hit;
    logic [SRC_W-1:0] win_idx;
    logic             irq_take;
    logic             take_exc;
    logic             take_irq;
    logic             take_eret;
    logic [31:0]      vec_base;
    logic [31:0]      vec_off;
    logic [31:0]      vec_pc;
    cop0_exc_data_t   cap;
    logic             unused_status;

    irq_synchronizer #(
        .N_IRQ(N_IRQ)
    ) u_irq_sync (
        .clk        (clk),
        .reset      (reset),
        .irq        (irq),
        .im         (status[STATUS_IM_LSB +: N_IRQ]),
        .irq_pending(irq_pending)
    );

    // Only a handful of Status bits matter here; fold the rest away
    assign unused_status = ^status;

    // Lowest-index valid source wins (scan from the top so index 0 lands last)
    always_comb begin
        src_hit = 1'b0;
        win_idx = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (src_valid[i]) begin
                src_hit = 1'b1;
                win_idx = SRC_W'(i);
            end
        end
    end

    // Event priority: source exception, then ERET, then interrupt.
    // An ERET beats a concurrent interrupt, leaving the interrupt pending.
    assign irq_take  = (|irq_pending) & status[STATUS_IE]
                     & ~status[STATUS_EXL] & ~status[STATUS_ERL];
    assign take_exc  = src_hit;
    assign take_eret = ~src_hit & eret;
    assign take_irq  = ~src_hit & ~eret & irq_take;

    // Vector target and exception record for the current winner
    always_comb begin
        vec_base = status[STATUS_BEV] ? BEV_BASE : ebase;
        vec_off  = (take_irq && cause_iv) ? OFF_IRQ : OFF_GENERAL;
        vec_pc   = vector_pc(vec_base, vec_off);
        cap      = '0;
        cap.exception_happen = 1'b1;
        if (take_exc) begin
            cap.exc_code  = src_code[win_idx];
            cap.epc       = src_epc[win_idx];
            cap.in_bd     = src_in_bd[win_idx];
            cap.badvaddr  = src_badvaddr[win_idx];
            cap.load_addr = src_load_addr[win_idx];
        end else begin
            // Interrupts never update BadVAddr, so its value is left zero
            cap.exc_code  = EXCCODE_INT;
            cap.epc       = irq_epc;
            cap.in_bd     = irq_in_bd;
        end
    end

    // Sequencer state and flush counter register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Next-state logic: accept in IDLE, count down the flush, hold redirect
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        accept     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (take_exc || take_irq || take_eret) begin
                    accept     = 1'b1;
                    state_next = ST_FLUSH;
                    cnt_next   = CNT_LOAD;
                end
            end
            ST_FLUSH: begin
                if (cnt == '0) begin
                    state_next = ST_REDIRECT;
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            ST_REDIRECT: begin
                if (redirect_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Registered outputs, decoded from the next state so they align with it
    always_ff @(posedge clk) begin
        if (reset) begin
            exc_data       <= '0;
            flush          <= 1'b0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            busy           <= 1'b0;
        end else begin
            flush          <= (state_next != ST_IDLE);
            busy           <= (state_next != ST_IDLE);
            redirect_valid <= (state_next == ST_REDIRECT);
            exc_data.exception_happen <= 1'b0;
            if (accept) begin
                if (take_eret) begin
                    redirect_pc <= eret_target;
                end else begin
                    redirect_pc <= vec_pc;
                    exc_data    <= cap;
                end
            end
        end
    end

    assign state_dbg = state;

endmodule
